// File: rtl/arm_mem_pkg.sv
// -----------------------------------------------------------------------------
// arm_mem_pkg
//
// Shared definitions for the ARM core memory subsystem.
//
// Contents:
//   ARM_MEM_AW / ARM_MEM_DW : default address and data widths of the core's
//                             memory buses.
//   arb_state_t             : state encoding of the memory arbiter FSM.
//   arb_is_busy()           : true while a memory transaction is outstanding.
// -----------------------------------------------------------------------------
package arm_mem_pkg;

    localparam int ARM_MEM_AW = 32;
    localparam int ARM_MEM_DW = 32;

    // IDLE    : arbitrating between fetch and data requests
    // IF_BUSY : a fetch owns the memory bus, waiting for mem_ack
    // DM_BUSY : a data access owns the memory bus, waiting for mem_ack
    // RESP    : one-cycle completion pulse back to the granted requester
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    // The two BUSY states are the only ones in which mem_ack means anything.
    function automatic logic arb_is_busy(input arb_state_t s);
        return (s == IF_BUSY) || (s == DM_BUSY);
    endfunction

endpackage : arm_mem_pkg

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-ported memory between the fetch stage (IF) and the memory
// stage (DM) of the pipeline. Data accesses normally win arbitration, but a
// saturating streak counter guarantees that a waiting fetch is served after
// MAX_DM_STREAK consecutive data grants.
//
// Parameters:
//   AW            : address width
//   DW            : data width
//   MAX_DM_STREAK : consecutive data grants allowed while a fetch waits
//
// Ports:
//   clk, rst                         : clock (rising edge), async active-low reset
//   if_req, if_addr                  : fetch read request
//   if_ready, if_rdata               : one-cycle fetch completion pulse and data
//   dm_req, dm_we, dm_addr, dm_wdata : data-stage request
//   dm_ready, dm_rdata               : one-cycle data completion pulse and data
//   mem_req, mem_we, mem_addr,
//   mem_wdata                        : registered request bus to the memory
//   mem_ack, mem_rdata               : memory completion and read data
//   stall_if, stall_mem              : per-stage stall requests
//
// Timing: a request sampled in IDLE at edge N puts mem_req on the bus in cycle
// N+1; the ready pulse appears in the cycle after mem_ack is sampled.
// -----------------------------------------------------------------------------
module mem_arbiter
    import arm_mem_pkg::*;
#(
    parameter int AW            = ARM_MEM_AW,
    parameter int DW            = ARM_MEM_DW,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ready,
    output logic [DW-1:0] if_rdata,

    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ready,
    output logic [DW-1:0] dm_rdata,

    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,

    output logic          stall_if,
    output logic          stall_mem
);

    // Wide enough to hold MAX_DM_STREAK itself, since the counter saturates there.
    localparam int            SW         = $clog2(MAX_DM_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);
    localparam logic [SW-1:0] STREAK_ONE = SW'(1);

    arb_state_t    state;
    logic [SW-1:0] streak;
    logic [SW-1:0] streak_next;

    logic          grant_dm;
    logic          grant_if;

    // Registered copies of the granted request; the memory bus is driven only
    // from these so requester changes after grant never reach the memory.
    logic          mem_req_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;

    // Captured read data and completion pulses for each requester.
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] dm_rdata_q;
    logic          if_ready_q;
    logic          dm_ready_q;

    // Arbitration decision, only meaningful in IDLE. Data wins unless it has
    // already used up its streak allowance, in which case a pending fetch goes.
    always_comb begin
        grant_dm = 1'b0;
        grant_if = 1'b0;
        if (state == IDLE) begin
            if (dm_req && (streak < STREAK_MAX)) begin
                grant_dm = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    // Streak bookkeeping. The count only measures how long a fetch has been
    // starved, so it resets whenever no fetch is waiting or a fetch is granted,
    // and grows by one for every data grant made past a waiting fetch.
    always_comb begin
        streak_next = streak;
        if (state == IDLE) begin
            if (!if_req || grant_if) begin
                streak_next = '0;
            end else if (grant_dm && (streak != STREAK_MAX)) begin
                streak_next = streak + STREAK_ONE;
            end
        end
    end

    // Main FSM with registered outputs. Reset clears everything at once, which
    // also drops mem_req asynchronously and aborts any transaction in flight
    // without a ready pulse. The ready pulses default low every cycle so they
    // can only ever last the single RESP cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            streak      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
        end else begin
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            streak     <= streak_next;

            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        state       <= DM_BUSY;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dm_we;
                        mem_addr_q  <= dm_addr;
                        mem_wdata_q <= dm_wdata;
                    end else if (grant_if) begin
                        state       <= IF_BUSY;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= '0;
                    end
                end

                IF_BUSY: begin
                    if (mem_ack) begin
                        state      <= RESP;
                        mem_req_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                        if_rdata_q <= mem_rdata;
                        if_ready_q <= 1'b1;
                    end
                end

                DM_BUSY: begin
                    if (mem_ack) begin
                        state      <= RESP;
                        mem_req_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                        dm_rdata_q <= mem_rdata;
                        dm_ready_q <= 1'b1;
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Everything facing the memory and the requesters comes straight from
    // registers; the captured data simply holds between RESP cycles.
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign if_ready  = if_ready_q;
    assign if_rdata  = if_rdata_q;
    assign dm_ready  = dm_ready_q;
    assign dm_rdata  = dm_rdata_q;

    // Stalls are combinational so a stage releases in the same cycle its
    // ready pulse arrives.
    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = dm_req & ~dm_ready;

endmodule : mem_arbiter
